// File: rtl/spi_slave.sv
// SPI slave endpoint supporting all four CPOL/CPHA modes.
//
// spi_clk, spi_cs_n and spi_di are oversampled in the clk_sys domain. Words are
// shifted MSB-first on one data line in each direction. Received words appear on
// rx_data with a one-cycle rx_valid pulse. A one-entry TX holding register
// supplies each outgoing word.
//
// Ports:
//   clk_sys, rst_n_sys  system clock, asynchronous active-low reset
//   cpol, cpha          SPI mode, latched while deselected
//   spi_clk, spi_cs_n,
//   spi_di              SPI inputs from the master (asynchronous)
//   spi_do, spi_do_en   slave data out and its output enable
//   tx_data, tx_wr      TX holding register write port
//   tx_ready            TX holding register empty
//   rx_data, rx_valid   last received word, new-word pulse
//   tx_underrun         pulse: word load found the TX register empty
//   frame_abort         pulse: CS deasserted mid-word
//   spi_busy            synchronized chip select active
module spi_slave #(
    parameter int unsigned G_SPI_DATA_WIDTH = 8,
    parameter int unsigned G_SYNC_STAGES    = 2
) (
    input  logic                        clk_sys,
    input  logic                        rst_n_sys,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        spi_clk,
    input  logic                        spi_cs_n,
    input  logic                        spi_di,
    output logic                        spi_do,
    output logic                        spi_do_en,
    input  logic [G_SPI_DATA_WIDTH-1:0] tx_data,
    input  logic                        tx_wr,
    output logic                        tx_ready,
    output logic [G_SPI_DATA_WIDTH-1:0] rx_data,
    output logic                        rx_valid,
    output logic                        tx_underrun,
    output logic                        frame_abort,
    output logic                        spi_busy
);

    localparam int unsigned W     = G_SPI_DATA_WIDTH;
    localparam int unsigned SS    = G_SYNC_STAGES;
    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // Synchronizers
    logic [SS-1:0] clk_sync_q;
    logic [SS-1:0] cs_sync_q;
    logic [SS-1:0] di_sync_q;
    // Marks when the synchronizers hold real pin samples rather than reset values
    logic [SS-1:0] fill_q;

    always_ff @(posedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            clk_sync_q <= '0;
            cs_sync_q  <= '1;
            di_sync_q  <= '0;
            fill_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[SS-2:0], spi_clk};
            cs_sync_q  <= {cs_sync_q[SS-2:0], spi_cs_n};
            di_sync_q  <= {di_sync_q[SS-2:0], spi_di};
            fill_q     <= {fill_q[SS-2:0], 1'b1};
        end
    end

    logic clk_s;
    logic cs_s;
    logic di_s;
    assign clk_s = clk_sync_q[SS-1];
    assign cs_s  = cs_sync_q[SS-1];
    assign di_s  = di_sync_q[SS-1];

    // State registers
    state_e           state_q, state_d;
    logic             clk_prev_q;
    logic             cs_prev_q;
    logic             busy_q;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]     rx_shift_q, rx_shift_d;
    logic [W-1:0]     rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [W-1:0]     tx_shift_q, tx_shift_d;
    logic [W-1:0]     tx_hold_q, tx_hold_d;
    logic             tx_full_q, tx_full_d;
    logic             first_edge_q, first_edge_d;
    logic             boundary_q, boundary_d;
    logic             underrun_q, underrun_d;
    logic             abort_q, abort_d;

    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic [W-1:0] rx_next;

    assign lead_edge   = (clk_s != cpol_q) && (clk_prev_q == cpol_q);
    assign trail_edge  = (clk_s == cpol_q) && (clk_prev_q != cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q && !cs_s;
    assign rx_next     = {rx_shift_q[W-2:0], di_s};

    always_comb begin
        logic word_load;
        word_load    = 1'b0;
        state_d      = state_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_shift_d   = tx_shift_q;
        tx_hold_d    = tx_hold_q;
        tx_full_d    = tx_full_q;
        first_edge_d = first_edge_q;
        boundary_d   = boundary_q;
        underrun_d   = 1'b0;
        abort_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cpol_d = cpol;
                cpha_d = cpha;
                if (cs_fall) begin
                    state_d      = StActive;
                    word_load    = 1'b1;
                    bit_cnt_d    = '0;
                    first_edge_d = 1'b1;
                    boundary_d   = 1'b0;
                end
            end
            StActive: begin
                if (cs_s) begin
                    state_d    = StIdle;
                    abort_d    = (bit_cnt_q != '0);
                    bit_cnt_d  = '0;
                    boundary_d = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (bit_cnt_q == CNT_W'(W - 1)) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                            boundary_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (boundary_q) begin
                            // With cpha=1 this edge is also the new word's first
                            // edge: the fresh MSB must stay put, so the
                            // first-edge flag is set and consumed here at once.
                            word_load    = 1'b1;
                            boundary_d   = 1'b0;
                            first_edge_d = 1'b0;
                        end else if (cpha_q && first_edge_q) begin
                            first_edge_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (word_load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_hold_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        // Writes only land in an empty register, even alongside a load
        if (tx_wr && !tx_full_q) begin
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            state_q      <= StIdle;
            clk_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            busy_q       <= 1'b0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_shift_q   <= '0;
            tx_hold_q    <= '0;
            tx_full_q    <= 1'b0;
            first_edge_q <= 1'b0;
            boundary_q   <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_prev_q   <= clk_s;
            // A CS fall only counts once CS was really seen high after reset,
            // so a frame interrupted by reset is not picked up mid-word.
            cs_prev_q    <= fill_q[SS-1] ? cs_s : 1'b0;
            busy_q       <= !cs_s;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_shift_q   <= tx_shift_d;
            tx_hold_q    <= tx_hold_d;
            tx_full_q    <= tx_full_d;
            first_edge_q <= first_edge_d;
            boundary_q   <= boundary_d;
            underrun_q   <= underrun_d;
            abort_q      <= abort_d;
        end
    end

    assign spi_do_en   = (state_q == StActive);
    assign spi_do      = (state_q == StActive) && tx_shift_q[W-1];
    assign tx_ready    = !tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_abort = abort_q;
    assign spi_busy    = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives frames in
// all four modes; expected RX words go into a queue that a monitor process
// pops whenever rx_valid pulses.
module tb_spi_slave;

    localparam int H = 8;  // SPI half period in clk_sys cycles

    logic       clk_sys;
    logic       rst_n_sys;
    logic       cpol;
    logic       cpha;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_di;
    logic       spi_do;
    logic       spi_do_en;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_abort;
    logic       spi_busy;

    spi_slave #(
        .G_SPI_DATA_WIDTH(8),
        .G_SYNC_STAGES   (2)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n_sys  (rst_n_sys),
        .cpol       (cpol),
        .cpha       (cpha),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_di     (spi_di),
        .spi_do     (spi_do),
        .spi_do_en  (spi_do_en),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .frame_abort(frame_abort),
        .spi_busy   (spi_busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    int n_unr    = 0;
    int n_abort  = 0;
    logic [7:0] exp_rx[$];
    logic cur_pol;
    logic cur_pha;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_valid and counts event pulses
    always @(negedge clk_sys) begin
        if (rx_valid) begin
            n_rx++;
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
        if (tx_underrun) n_unr++;
        if (frame_abort) n_abort++;
    end

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk_sys);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk_sys);
        tx_wr   = 1'b0;
    endtask

    task automatic frame_begin(input logic pol, input logic pha);
        @(negedge clk_sys);
        cur_pol = pol;
        cur_pha = pha;
        cpol    = pol;
        cpha    = pha;
        spi_clk = pol;
        repeat (10) @(negedge clk_sys);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk_sys);
    endtask

    task automatic frame_end();
        if (!cur_pha) repeat (H) @(negedge clk_sys);
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk_sys);
    endtask

    // Clocks out the top nbits of mo, returns what the master sampled on spi_do
    task automatic xfer_word(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cur_pha) begin
                spi_di = mo[i];
                repeat (H) @(negedge clk_sys);
                spi_clk = ~cur_pol;
                mi = {mi[6:0], spi_do};
                repeat (H) @(negedge clk_sys);
                spi_clk = cur_pol;
            end else begin
                spi_clk = ~cur_pol;
                spi_di  = mo[i];
                repeat (H) @(negedge clk_sys);
                spi_clk = cur_pol;
                mi = {mi[6:0], spi_do};
                repeat (H) @(negedge clk_sys);
            end
        end
    endtask

    task automatic send_word(input string name, input logic [7:0] mo, input logic [7:0] exp_mi);
        logic [7:0] mi;
        exp_rx.push_back(mo);
        xfer_word(mo, 8, mi);
        check(name, {24'd0, mi}, {24'd0, exp_mi});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_do"},      {31'd0, spi_do},      32'd0);
        check({tag, "_spi_do_en"},   {31'd0, spi_do_en},   32'd0);
        check({tag, "_tx_ready"},    {31'd0, tx_ready},    32'd1);
        check({tag, "_rx_data"},     {24'd0, rx_data},     32'd0);
        check({tag, "_rx_valid"},    {31'd0, rx_valid},    32'd0);
        check({tag, "_tx_underrun"}, {31'd0, tx_underrun}, 32'd0);
        check({tag, "_frame_abort"}, {31'd0, frame_abort}, 32'd0);
        check({tag, "_spi_busy"},    {31'd0, spi_busy},    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         rx0;
        int         unr0;
        int         ab0;
        logic [7:0] mi;
        rst_n_sys = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        spi_clk   = 1'b0;
        spi_cs_n  = 1'b1;
        spi_di    = 1'b0;
        tx_data   = 8'h00;
        tx_wr     = 1'b0;
        cur_pol   = 1'b0;
        cur_pha   = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_reset_outputs("rst");
        rst_n_sys = 1'b1;
        repeat (5) @(negedge clk_sys);
        check_reset_outputs("post_rst");

        // Mode 0, one byte
        tx_write(8'h3C);
        check("t1_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        rx0 = n_rx;
        frame_begin(1'b0, 1'b0);
        check("t1_spi_do_en", {31'd0, spi_do_en}, 32'd1);
        check("t1_spi_busy", {31'd0, spi_busy}, 32'd1);
        send_word("t1_miso", 8'hA5, 8'h3C);
        frame_end();
        check("t1_rx_count", n_rx - rx0, 1);
        check("t1_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("t1_spi_do_en_off", {31'd0, spi_do_en}, 32'd0);

        // Mode 3, two-word frame, second word written once the first is loaded
        tx_write(8'h81);
        rx0  = n_rx;
        unr0 = n_unr;
        fork
            begin
                frame_begin(1'b1, 1'b1);
                send_word("t2_miso_w0", 8'h12, 8'h81);
                send_word("t2_miso_w1", 8'h34, 8'h7E);
                frame_end();
            end
            begin
                int waited;
                waited = 0;
                while (!tx_ready && waited < 400) begin
                    @(negedge clk_sys);
                    waited++;
                end
                if (!tx_ready) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL t2_tx_ready_wait: got 0, expected 1 within 400 cycles");
                end
                tx_write(8'h7E);
            end
        join
        check("t2_rx_count", n_rx - rx0, 2);
        check("t2_underrun_count", n_unr - unr0, 0);

        // Mode 1, TX register empty at CS fall
        rx0  = n_rx;
        unr0 = n_unr;
        frame_begin(1'b0, 1'b1);
        send_word("t3_miso", 8'h5A, 8'h00);
        frame_end();
        check("t3_underrun_count", n_unr - unr0, 1);
        check("t3_rx_count", n_rx - rx0, 1);

        // Mode 2, CS raised after 5 bits, then a full frame
        rx0 = n_rx;
        ab0 = n_abort;
        frame_begin(1'b1, 1'b0);
        xfer_word(8'hF8, 5, mi);
        frame_end();
        check("t4_abort_count", n_abort - ab0, 1);
        check("t4_rx_count", n_rx - rx0, 0);
        check("t4_spi_do_en", {31'd0, spi_do_en}, 32'd0);
        tx_write(8'h99);
        frame_begin(1'b1, 1'b0);
        send_word("t4_miso", 8'hC3, 8'h99);
        frame_end();
        check("t4_rx_count_after", n_rx - rx0, 1);

        // Write while full: the second write is dropped
        tx_write(8'h11);
        tx_write(8'h22);
        check("t5_tx_ready", {31'd0, tx_ready}, 32'd0);
        frame_begin(1'b0, 1'b0);
        send_word("t5_miso", 8'h69, 8'h11);
        frame_end();

        // Reset mid-frame after 3 bits
        tx_write(8'h55);
        rx0 = n_rx;
        ab0 = n_abort;
        frame_begin(1'b0, 1'b0);
        xfer_word(8'hAA, 3, mi);
        @(negedge clk_sys);
        rst_n_sys = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (3) @(negedge clk_sys);
        rst_n_sys = 1'b1;
        xfer_word(8'h00, 5, mi);
        check("t6_spi_do_en_after", {31'd0, spi_do_en}, 32'd0);
        frame_end();
        check("t6_rx_count", n_rx - rx0, 0);
        check("t6_abort_count", n_abort - ab0, 0);
        frame_begin(1'b0, 1'b0);
        check("t6_resume_do_en", {31'd0, spi_do_en}, 32'd1);
        send_word("t6_miso", 8'hE7, 8'h00);
        frame_end();
        check("t6_rx_count_after", n_rx - rx0, 1);

        repeat (10) @(negedge clk_sys);
        check("rx_queue_drained", exp_rx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
